// File: rtl/load_store_unit_pkg.sv
// rtl/load_store_unit_pkg.sv - shared encodings and request type for the load/store unit
package load_store_unit_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [1:0] FAULT_NONE       = 2'b00;
    localparam logic [1:0] FAULT_MISALIGNED = 2'b01;
    localparam logic [1:0] FAULT_ILLEGAL    = 2'b10;
    localparam logic [1:0] FAULT_TIMEOUT    = 2'b11;

    localparam logic MEM_READ  = 1'b0;
    localparam logic MEM_WRITE = 1'b1;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ISSUE   = 2'd1;
    localparam logic [1:0] ST_WAIT    = 2'd2;
    localparam logic [1:0] ST_RESPOND = 2'd3;

    typedef struct packed {
        logic        is_store;
        logic [2:0]  funct3;
        logic [31:0] address;
        logic [31:0] store_data;
    } lsu_req_t;

    function automatic logic [31:0] word_base(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - control side of the byte-serial memory interface
interface load_store_unit_if;
    logic        mem_enable;
    logic        mem_state;
    logic [3:0]  mem_frame_mask;
    logic [31:0] mem_address;
    logic        mem_done;

    modport master (
        output mem_enable,
        output mem_state,
        output mem_frame_mask,
        output mem_address,
        input  mem_done
    );

    modport slave (
        input  mem_enable,
        input  mem_state,
        input  mem_frame_mask,
        input  mem_address,
        output mem_done
    );
endinterface

// File: rtl/load_store_unit_data_align.sv
// rtl/load_store_unit_data_align.sv - lane mask, legality checks, store alignment and load extension
module lsu_data_align
    import load_store_unit_pkg::*;
(
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] raw_load,
    output logic [3:0]  frame_mask,
    output logic        misaligned,
    output logic        illegal,
    output logic [31:0] store_bus,
    output logic [31:0] load_value
);

    always_comb begin
        frame_mask = 4'b0000;
        misaligned = 1'b0;
        store_bus  = 32'h0;
        if (is_store) begin
            illegal = !(funct3 inside {F3_SB, F3_SH, F3_SW});
        end else begin
            illegal = !(funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
        end
        // funct3[1:0] is the access width for both loads and stores
        case (funct3[1:0])
            2'b00: begin
                frame_mask = 4'b1000 >> addr_lo;
                store_bus  = {24'h0, store_data[7:0]};
            end
            2'b01: begin
                frame_mask = addr_lo[1] ? 4'b0011 : 4'b1100;
                misaligned = addr_lo[0];
                store_bus  = {16'h0, store_data[15:0]};
            end
            2'b10: begin
                frame_mask = 4'b1111;
                misaligned = |addr_lo;
                store_bus  = store_data;
            end
            default: begin
                frame_mask = 4'b0000;
            end
        endcase
    end

    always_comb begin
        load_value = 32'h0;
        case (funct3)
            F3_LB:   load_value = {{24{raw_load[7]}}, raw_load[7:0]};
            F3_LBU:  load_value = {24'h0, raw_load[7:0]};
            F3_LH:   load_value = {{16{raw_load[15]}}, raw_load[15:0]};
            F3_LHU:  load_value = {16'h0, raw_load[15:0]};
            F3_LW:   load_value = raw_load;
            default: load_value = 32'h0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - execute-side load/store sequencer in front of the byte-serial memory interface
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                     CLK,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     is_store,
    input  logic [2:0]               funct3,
    input  logic [31:0]              address,
    input  logic [31:0]              store_data,
    output logic                     busy,
    output logic                     done,
    output logic [1:0]               fault,
    output logic [31:0]              load_data,
    load_store_unit_if.master        mem,
    inout  wire  [31:0]              mem_data
);

    logic [1:0]  state;
    lsu_req_t    req_q;
    logic [7:0]  wait_cnt;
    logic [1:0]  fault_q;
    logic [31:0] load_data_q;
    logic        mem_enable_q;
    logic        mem_state_q;
    logic [3:0]  mem_mask_q;
    logic [31:0] mem_address_q;

    logic        sel_is_store;
    logic [2:0]  sel_funct3;
    logic [1:0]  sel_addr_lo;
    logic [31:0] sel_store_data;
    logic [3:0]  frame_mask;
    logic        misaligned;
    logic        illegal;
    logic [31:0] store_bus;
    logic [31:0] load_value;
    logic        timeout_hit;
    logic        drive_bus;

    // In IDLE the checker looks at the incoming request; afterwards at the latched one
    always_comb begin
        if (state == ST_IDLE) begin
            sel_is_store   = is_store;
            sel_funct3     = funct3;
            sel_addr_lo    = address[1:0];
            sel_store_data = store_data;
        end else begin
            sel_is_store   = req_q.is_store;
            sel_funct3     = req_q.funct3;
            sel_addr_lo    = req_q.address[1:0];
            sel_store_data = req_q.store_data;
        end
    end

    lsu_data_align u_align (
        .is_store   (sel_is_store),
        .funct3     (sel_funct3),
        .addr_lo    (sel_addr_lo),
        .store_data (sel_store_data),
        .raw_load   (mem_data),
        .frame_mask (frame_mask),
        .misaligned (misaligned),
        .illegal    (illegal),
        .store_bus  (store_bus),
        .load_value (load_value)
    );

    assign timeout_hit = (wait_cnt == 8'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge CLK) begin
        if (reset) begin
            state         <= ST_IDLE;
            req_q         <= '0;
            wait_cnt      <= 8'h0;
            fault_q       <= FAULT_NONE;
            load_data_q   <= 32'h0;
            mem_enable_q  <= 1'b0;
            mem_state_q   <= MEM_READ;
            mem_mask_q    <= 4'b0000;
            mem_address_q <= 32'h0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        req_q <= '{is_store: is_store, funct3: funct3,
                                   address: address, store_data: store_data};
                        if (illegal) begin
                            state       <= ST_RESPOND;
                            fault_q     <= FAULT_ILLEGAL;
                            load_data_q <= 32'h0;
                        end else if (misaligned) begin
                            state       <= ST_RESPOND;
                            fault_q     <= FAULT_MISALIGNED;
                            load_data_q <= 32'h0;
                        end else begin
                            state         <= ST_ISSUE;
                            mem_enable_q  <= 1'b1;
                            mem_state_q   <= is_store ? MEM_WRITE : MEM_READ;
                            mem_mask_q    <= frame_mask;
                            mem_address_q <= word_base(address);
                        end
                    end
                end
                ST_ISSUE: begin
                    wait_cnt <= 8'h0;
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    wait_cnt <= wait_cnt + 8'h1;
                    // mem_done takes priority over a timeout in the same cycle
                    if (mem.mem_done) begin
                        state        <= ST_RESPOND;
                        fault_q      <= FAULT_NONE;
                        load_data_q  <= req_q.is_store ? 32'h0 : load_value;
                        mem_enable_q <= 1'b0;
                        mem_mask_q   <= 4'b0000;
                    end else if (timeout_hit) begin
                        state        <= ST_RESPOND;
                        fault_q      <= FAULT_TIMEOUT;
                        load_data_q  <= 32'h0;
                        mem_enable_q <= 1'b0;
                        mem_mask_q   <= 4'b0000;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_RESPOND);
    assign fault     = fault_q;
    assign load_data = load_data_q;

    assign mem.mem_enable     = mem_enable_q;
    assign mem.mem_state      = mem_state_q;
    assign mem.mem_frame_mask = mem_mask_q;
    assign mem.mem_address    = mem_address_q;

    assign drive_bus = (mem_state_q == MEM_WRITE) && ((state == ST_ISSUE) || (state == ST_WAIT));
    assign mem_data  = drive_bus ? store_bus : 32'hzzzz_zzzz;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Execute-side load/store sequencer that sits directly upstream of the byte-serial memory interface.
- Accepts one RISC-V load/store request per handshake.
- Splits the address into a word-aligned base plus a frame mask, and drives the interface's enable/state/mask/address/data bus.
- Waits for memory_done, then returns sign- or zero-extended load data or a fault code to the pipeline.

Parameters:
TIMEOUT_CYCLES, 16, maximum WAIT cycles before the access is aborted with a timeout fault (legal range 4..255).

Ports:
CLK  input  1  clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  request strobe; sampled only in IDLE.
is_store  input  1  1 = store, 0 = load.
funct3  input  3  RISC-V width/sign code.
address  input  32  byte effective address.
store_data  input  32  store operand; the low bytes are used.
busy  output  1  high in every state except IDLE.
done  output  1  one-cycle completion pulse.
fault  output  2  valid with done: 00 ok, 01 misaligned, 10 illegal funct3, 11 timeout.
load_data  output  32  extended load result; valid with done.
mem_enable  output  1  to interface enable.
mem_state  output  1  0 = READ, 1 = WRITE.
mem_frame_mask  output  4  byte-lane mask.
mem_address  output  32  word-aligned base address {addr[31:2],2'b00}.
mem_data  inout  32  shared data bus.
mem_done  input  1  completion from the interface.

Behaviour:
- States: IDLE, ISSUE, WAIT, RESPOND.
- Reset values:
  - state IDLE.
  - busy 0, done 0, fault 00, load_data 0.
  - mem_enable 0, mem_state 0, mem_frame_mask 0000, mem_address 0.
  - mem_data released (high-Z).
  - timeout counter 0.
- A reset asserted mid-access returns to IDLE on that edge and drops mem_enable. The interface then returns to its idle state; no done pulse is produced.
- IDLE, start=1:
  - Latch is_store, funct3, address, store_data.
  - Legal funct3 for loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Legal for stores: 000, 001, 010.
  - Illegal funct3 -> RESPOND with fault 10.
  - Misaligned (half with addr[0]=1, word with addr[1:0]!=0) -> RESPOND with fault 01.
  - A faulted request never asserts mem_enable.
  - Otherwise -> ISSUE.
- start while busy is ignored (not queued).
- Mask, indexed by addr[1:0]:
  - Byte: 0 -> 1000, 1 -> 0100, 2 -> 0010, 3 -> 0001.
  - Half: 0 -> 1100, 2 -> 0011.
  - Word: 1111.
- ISSUE (1 cycle):
  - Assert mem_enable; drive mem_state, mem_frame_mask, mem_address from the latched values.
  - Clear the timeout counter. Go to WAIT.
- WAIT:
  - Hold all mem_* outputs stable; increment the counter each cycle.
  - If mem_done=1: capture mem_data (loads) and go to RESPOND with fault 00.
  - Else if the counter reaches TIMEOUT_CYCLES-1: go to RESPOND with fault 11.
  - If mem_done and the timeout coincide, mem_done wins.
- RESPOND (1 cycle):
  - done=1; mem_enable=0; mem_frame_mask=0000. Next state IDLE.
  - A new start can be accepted on the following cycle.
- mem_data drive:
  - Driven only while mem_state=1 (store) in ISSUE and WAIT; high-Z in all other states.
  - Store data is placed low-aligned: SB -> store_data[7:0] on bus[7:0]; SH -> [15:0]; SW -> [31:0]; unused bits 0.
- Load extension (the bus returns data low-aligned):
  - LB: sign-extend bit 7. LBU: zero-extend [7:0].
  - LH: sign-extend bit 15. LHU: zero-extend [15:0].
  - LW: pass [31:0].
- load_data holds its value until the next done; it is 0 for stores and for any faulted access.
- Latency: done is asserted exactly one cycle after the cycle in which mem_done is sampled high.

Decomposition:
- Shared defines header lsu_defs:
  - funct3 codes (LB/LH/LW/LBU/LHU, SB/SH/SW).
  - FAULT_NONE/MISALIGNED/ILLEGAL/TIMEOUT encodings.
  - READ/WRITE encodings.
  - FSM state encodings.
- One combinational sub-module, lsu_data_align:
  - Inputs funct3, addr[1:0], store_data, raw load data.
  - Outputs frame mask, misaligned flag, illegal flag, aligned store bus value, extended load value.

Test Plan:
- LB at address 0x0000_0043, memory byte 0x80, interface done after 3 cycles -> mem_frame_mask 0001, mem_address 0x40, load_data 0xFFFF_FF80, fault 00, done one cycle after mem_done.
- LHU at 0x0000_0012 returning 0x8001 -> mask 0011, load_data 0x0000_8001. Repeat as LH -> 0xFFFF_8001.
- SW 0xDEADBEEF at 0x20 -> mem_state 1, mask 1111, mem_data 0xDEADBEEF during ISSUE/WAIT, high-Z after done; a follow-up LW at 0x20 reads 0xDEADBEEF.
- LW at 0x0000_0022 -> done in the cycle after start with fault 01; mem_enable never asserted. SB with funct3 100 -> fault 10.
- Load with mem_done held low -> done with fault 11 after TIMEOUT_CYCLES WAIT cycles (16 by default); mem_enable dropped in RESPOND.
- reset pulsed in WAIT of an SW -> next cycle IDLE, mem_enable 0, bus high-Z, no done. start asserted while busy -> ignored, exactly one done pulse.
